register_file_rw: RTL
=====================

# register_file_rw

Parametrised register file for the ALU/DMAC datapath, succeeding the fixed 8×32 combinational read selector. It provides one write port, one registered random-access read port and one streaming burst-read port with valid/ready flow control. The DMAC uses the burst port to drain consecutive registers as a stream. The ALU uses the random-access port for operand fetch.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 8, number of registers (≥2, need not be a power of two)
- ADDR_WIDTH, $clog2(NUM_REGS), address width (derived, not overridden)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  random read request
- rd_addr  in  ADDR_WIDTH  random read address
- rd_data  out  DATA_WIDTH  random read data (registered)
- rd_valid  out  1  rd_data holds a fresh result this cycle
- bst_start  in  1  burst request, sampled only when bst_busy=0
- bst_addr  in  ADDR_WIDTH  burst start address
- bst_len  in  ADDR_WIDTH+1  burst beat count, 1..NUM_REGS
- bst_data  out  DATA_WIDTH  burst beat data
- bst_valid  out  1  beat present
- bst_ready  in  1  consumer accepts beat
- bst_last  out  1  current beat is final
- bst_busy  out  1  burst in progress

## Operation
- Reset: all registers, rd_data, bst_data ← 0. rd_valid, bst_valid, bst_last and bst_busy ← 0. FSM ← IDLE. Reset overrides every other input in the same cycle, including during an active burst.
- Write: when wr_en=1 and wr_addr<NUM_REGS, regs[wr_addr] ← wr_data at the edge. Out-of-range writes are ignored.
- Random read: when rd_en=1, rd_data ← regs[rd_addr] and rd_valid ← 1 at the next edge. Otherwise rd_valid ← 0 and rd_data holds its last value.
  - Write-first bypass: if wr_en=1 and wr_addr=rd_addr in the same cycle, wr_data is returned.
  - Out-of-range rd_addr returns 0.
- Burst FSM, states IDLE and STREAM:
  - IDLE → STREAM on bst_start=1 with 1≤bst_len≤NUM_REGS. Load ptr←bst_addr and rem←bst_len, and capture the first beat with bypass.
  - bst_start with bst_len=0, bst_len>NUM_REGS, or bst_addr out of range is ignored.
  - STREAM: a handshake is bst_valid & bst_ready.
    - On handshake with rem>1: ptr ← (ptr+1) mod NUM_REGS, so NUM_REGS−1 wraps to 0. rem ← rem−1. The next beat is captured from the new ptr with write-first bypass.
    - On handshake with rem=1: → IDLE, with bst_valid, bst_last and bst_busy ← 0.
  - Without a handshake, bst_data and bst_last stay stable. Writes to the register under ptr do not alter the held beat.
  - bst_last = (rem=1) while bst_valid.
  - bst_start while bst_busy=1 is ignored.
- The random read port and write port operate concurrently with a burst. There is no arbitration stall.

## Timing
- Random read latency: request at cycle t → rd_valid/rd_data at t+1. One read per cycle; back-to-back requests give continuous rd_valid.
- Burst: accepted start at t → bst_valid and bst_busy high from t+1.
  - With bst_ready held high, beats appear at t+1..t+len, bst_last at t+len, and bst_busy is low from t+len+1.
  - The next bst_start is accepted no earlier than t+len+1.
- A stall of k cycles (bst_ready=0) extends the burst by exactly k cycles. No beat is lost or duplicated.
- Reset asserted at any cycle → all outputs at reset values after that edge.

## Test plan
- Reset, then rd_en sweep over addrs 0..7 → rd_valid=1 each cycle t+1, rd_data=0 for all.
- Write 0xDEADBEEF to reg 5 with rd_en/rd_addr=5 in the same cycle → rd_data=0xDEADBEEF next cycle (bypass). A later read of reg 5 returns the same value.
- Preload regs[i]=0x11·i, then burst bst_addr=6, bst_len=4 with bst_ready=1:
  - beats 0x66, 0x77, 0x00, 0x11 (wrap) on consecutive cycles;
  - bst_last only on 0x11;
  - bst_busy low the cycle after.
- Same burst with bst_ready=0 for 3 cycles on beat 2, while writing 0xAAAA to reg 7 during the stall:
  - bst_data stays 0x77 and does not change to 0xAAAA;
  - then 0x00, 0x11 follow;
  - total burst length 7 cycles.
- Reset asserted on beat 2 of an 8-beat burst:
  - bst_valid, bst_busy, bst_last = 0 next cycle;
  - all registers read 0;
  - new bst_start accepted immediately.
- Ignored requests:
  - bst_len=0 → bst_busy stays 0;
  - bst_start during busy → no effect on the current beat count.
- NUM_REGS=6: read addr 7 → rd_data=0; write addr 6 → no register changes.

Source files
------------

// File: rtl/register_file_rw.sv
// Parametrised register file: one write port, a registered random read port and
// a valid/ready burst-read port that streams consecutive registers with wrap-around.
module register_file_rw #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  bst_start,
  input  logic [ADDR_WIDTH-1:0] bst_addr,
  input  logic [ADDR_WIDTH:0]   bst_len,
  output logic [DATA_WIDTH-1:0] bst_data,
  output logic                  bst_valid,
  input  logic                  bst_ready,
  output logic                  bst_last,
  output logic                  bst_busy
);

  localparam logic [ADDR_WIDTH:0]   NREGS_W   = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wr_hit;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [DATA_WIDTH-1:0] r_bst_data;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic [ADDR_WIDTH:0]   w_rem_next;
  logic [DATA_WIDTH-1:0] w_bst_data_next;
  logic [ADDR_WIDTH-1:0] w_ptr_inc;
  logic                  w_handshake;
  logic                  w_start_ok;

  // Out-of-range write addresses match no slot, so they fall away naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_hit
      assign w_wr_hit[gi] = wr_en && (wr_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Write-first lookup shared by both read paths; unmatched addresses read as zero.
  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_WIDTH'(i)) v = w_wr_hit[i] ? wr_data : r_regs[i];
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset)            r_regs[i] <= '0;
      else if (w_wr_hit[i]) r_regs[i] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= f_read(rd_addr);
    end
  end

  assign w_handshake = (r_state == S_STREAM) && bst_ready;
  assign w_ptr_inc   = (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
  assign w_start_ok  = bst_start && (bst_len != '0) && (bst_len <= NREGS_W)
                       && ({1'b0, bst_addr} < NREGS_W);

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_rem_next      = r_rem;
    w_bst_data_next = r_bst_data;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next    = S_STREAM;
          w_ptr_next      = bst_addr;
          w_rem_next      = bst_len;
          w_bst_data_next = f_read(bst_addr);
        end
      end
      S_STREAM: begin
        if (w_handshake) begin
          if (r_rem == REM_ONE) begin
            w_state_next = S_IDLE;
          end else begin
            w_ptr_next      = w_ptr_inc;
            w_rem_next      = r_rem - 1'b1;
            w_bst_data_next = f_read(w_ptr_inc);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_bst_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_rem      <= w_rem_next;
      r_bst_data <= w_bst_data_next;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign bst_data  = r_bst_data;
  assign bst_busy  = (r_state == S_STREAM);
  assign bst_valid = (r_state == S_STREAM);
  assign bst_last  = (r_state == S_STREAM) && (r_rem == REM_ONE);

endmodule
